// File: rtl/scanout_fetch_if.sv
// Framebuffer read port between the scanout engine and the front-buffer memory.
//   rd_en   : one-CLK read strobe from the scanout engine
//   rd_addr : word address, valid together with rd_en
//   rd_data : synchronous read data, valid one CLK after rd_en and held until the next read
// master = scanout side, slave = memory side.
interface scanout_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/scanout_fetch.sv
// Display scanout engine for the double-buffered framebuffer.
// Generates VGA-style raster timing, fetches upscaled pixels from the front
// buffer and emits RGB, sync and data-enable mutually aligned.
// Ports:
//   CLK, rst     : system clock, synchronous active-high reset
//   side         : front-buffer index from the swap block
//   mem          : framebuffer read port (rd_en / rd_addr out, rd_data in)
//   hsync, vsync : registered sync outputs, polarity set by *_ACTIVE_LOW
//   de, rgb      : data enable and pixel value (rgb forced to 0 when de=0)
//   frame_start  : one-CLK pulse on the pixel tick at raster (0,0)
//   fetch_side   : buffer index used by the frame in progress
module scanout_fetch #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int PIX_DIV       = 4,
    parameter int FB_W          = 160,
    parameter int FB_H          = 120,
    parameter int SCALE_SHIFT   = 2,
    parameter int ADDR_W        = 16,
    parameter int PIX_W         = 12
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               side,
    scanout_fetch_if.master    mem,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [PIX_W-1:0]   rgb,
    output logic               frame_start,
    output logic               fetch_side
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_IDLE  = (HS_ACTIVE_LOW != 0);
    localparam logic          VS_IDLE  = (VS_ACTIVE_LOW != 0);

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic              fetch_side_q, fetch_side_d;

    logic pix_ce;
    logic active;
    logic hs_raw, vs_raw;

    assign pix_ce = (div_q == '0);
    assign active = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_raw = (v_q >= VS_BEG) && (v_q < VS_END);

    always_comb begin
        div_d        = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d          = h_q;
        v_d          = v_q;
        rd_en_d      = 1'b0;   // strobe lasts one CLK whatever PIX_DIV is
        rd_addr_d    = rd_addr_q;
        hs1_d        = hs1_q;
        vs1_d        = vs1_q;
        de1_d        = de1_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        de_d         = de_q;
        rgb_d        = rgb_q;
        fetch_side_d = fetch_side_q;

        if (pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            // Stage 1: issue the read for the current raster position.
            // The modulo-2^ADDR_W truncation is intended.
            rd_en_d   = active;
            rd_addr_d = (fetch_side_q ? ADDR_W'(FB_SIZE) : '0)
                      + ADDR_W'(v_q >> SCALE_SHIFT) * ADDR_W'(FB_W)
                      + ADDR_W'(h_q >> SCALE_SHIFT);
            hs1_d     = hs_raw;
            vs1_d     = vs_raw;
            de1_d     = active;

            // Stage 2: rd_data has been stable since at least one CLK
            // after the stage-1 read, because PIX_DIV >= 2.
            rgb_d   = de1_q ? mem.rd_data : '0;
            de_d    = de1_q;
            hsync_d = hs1_q ? ~HS_IDLE : HS_IDLE;
            vsync_d = vs1_q ? ~VS_IDLE : VS_IDLE;

            // Sample the front buffer only at the last pixel of the frame,
            // so a swap takes effect on a frame boundary and never tears.
            if ((h_q == H_LAST) && (v_q == V_LAST)) begin
                fetch_side_d = side;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            de1_q        <= 1'b0;
            hsync_q      <= HS_IDLE;
            vsync_q      <= VS_IDLE;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            fetch_side_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            de1_q        <= de1_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            fetch_side_q <= fetch_side_d;
        end
    end

    assign mem.rd_en   = rd_en_q;
    assign mem.rd_addr = rd_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign fetch_side  = fetch_side_q;
    // The divider sits at 0 while rst is held, so the pulse is gated to keep it low then.
    assign frame_start = pix_ce && !rst && (h_q == '0) && (v_q == '0);
endmodule

// File: tb/tb_scanout_fetch.sv
// Bench for scanout_fetch with a reduced raster (24x17 pixel ticks, PIX_DIV=2)
// and an exact one-CLK-latency framebuffer model. Expected outputs are derived
// from the cycle count since reset release: pixel tick, raster position,
// address and pixel value are computed arithmetically for every cycle.
module tb_scanout_fetch;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
    localparam int P  = 2;
    localparam int FBW = 4, FBH = 3, SS = 2;
    localparam int HT = HA + HFP + HSY + HBP;   // 24
    localparam int VT = VA + VFP + VSY + VBP;   // 17
    localparam int F  = HT * VT;                // ticks per frame
    localparam int FBS = FBW * FBH;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        side = 1'b0;
    logic        hsync, vsync, de, frame_start, fetch_side;
    logic [11:0] rgb;

    scanout_fetch_if #(.ADDR_W(16), .PIX_W(12)) mif ();

    scanout_fetch #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1), .PIX_DIV(P),
        .FB_W(FBW), .FB_H(FBH), .SCALE_SHIFT(SS), .ADDR_W(16), .PIX_W(12)
    ) dut (
        .CLK(CLK), .rst(rst), .side(side), .mem(mif),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .frame_start(frame_start), .fetch_side(fetch_side)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [11:0] memfn(input int a);
        return 12'(a) ^ 12'h5A5;
    endfunction

    // Framebuffer model: exact one-CLK read latency, data held between reads.
    initial begin
        mif.rd_data = '0;
        forever begin
            @(posedge CLK);
            if (mif.rd_en) mif.rd_data <= memfn(int'(mif.rd_addr));
        end
    end

    // ---------------- behavioural model ----------------
    bit fs_map [int];   // front buffer chosen for each frame index

    function automatic int fs_of(input int f);
        return fs_map.exists(f) ? int'(fs_map[f]) : 0;
    endfunction
    function automatic int hp(input int t); return t % HT; endfunction
    function automatic int vp(input int t); return (t / HT) % VT; endfunction
    function automatic bit act(input int t); return hp(t) < HA && vp(t) < VA; endfunction
    function automatic bit hs_on(input int t);
        return hp(t) >= HA + HFP && hp(t) < HA + HFP + HSY;
    endfunction
    function automatic bit vs_on(input int t);
        return vp(t) >= VA + VFP && vp(t) < VA + VFP + VSY;
    endfunction
    function automatic int addr_of(input int t);
        return (fs_of(t / F) * FBS + (vp(t) >> SS) * FBW + (hp(t) >> SS)) & 'hFFFF;
    endfunction

    int n_checks = 0;
    int n_errors = 0;
    int n_m = 0;
    int seg = 0;
    bit rst_s = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s seg=%0d cyc=%0d actual=%0h required=%0h", nm, seg, n_m, a, e);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        rst_s = rst;
    end

    // Compare process: every cycle, sampled on the falling edge.
    initial forever begin
        int t, t1, t2;
        logic e_rd_en, e_de, e_hs, e_vs, e_fs, e_fst;
        logic [15:0] e_addr;
        logic [11:0] e_rgb;
        @(negedge CLK);
        if (rst) begin
            if (rst_s) begin
                chk("rst_rd_en", 32'(mif.rd_en), 0);
                chk("rst_rd_addr", 32'(mif.rd_addr), 0);
                chk("rst_rgb", 32'(rgb), 0);
                chk("rst_de", 32'(de), 0);
                chk("rst_hsync", 32'(hsync), 1);
                chk("rst_vsync", 32'(vsync), 1);
                chk("rst_frame_start", 32'(frame_start), 0);
                chk("rst_fetch_side", 32'(fetch_side), 0);
            end
            n_m = 0;
            fs_map.delete();
            fs_map[0] = 1'b0;
        end else begin
            if (n_m == 0) seg++;
            t = n_m / P;
            e_fst = (n_m % P == 0) && (t % F == 0);
            e_fs  = (n_m == 0) ? 1'b0 : 1'(fs_of(((n_m - 1) / P + 1) / F));
            if (n_m >= 1) begin
                t1      = (n_m - 1) / P;
                e_rd_en = act(t1) && ((n_m - 1) % P == 0);
                e_addr  = 16'(addr_of(t1));
            end else begin
                e_rd_en = 1'b0;
                e_addr  = '0;
            end
            if (n_m - 1 >= P) begin
                t2    = (n_m - 1) / P - 1;
                e_de  = act(t2);
                e_hs  = !hs_on(t2);
                e_vs  = !vs_on(t2);
                e_rgb = e_de ? memfn(addr_of(t2)) : '0;
            end else begin
                e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
            end
            chk("rd_en", 32'(mif.rd_en), 32'(e_rd_en));
            chk("rd_addr", 32'(mif.rd_addr), 32'(e_addr));
            chk("de", 32'(de), 32'(e_de));
            chk("hsync", 32'(hsync), 32'(e_hs));
            chk("vsync", 32'(vsync), 32'(e_vs));
            chk("rgb", 32'(rgb), 32'(e_rgb));
            chk("frame_start", 32'(frame_start), 32'(e_fst));
            chk("fetch_side", 32'(fetch_side), 32'(e_fs));

            // Hand-computed points for this raster geometry.
            if (seg == 1) begin
                case (n_m)
                    0:   begin chk("lit_fs0", 32'(frame_start), 1);
                               chk("lit_hs0", 32'(hsync), 1);
                               chk("lit_vs0", 32'(vsync), 1); end
                    1:   begin chk("lit_rden1", 32'(mif.rd_en), 1);
                               chk("lit_addr1", 32'(mif.rd_addr), 0); end
                    2:   begin chk("lit_rden2", 32'(mif.rd_en), 0);
                               chk("lit_de2", 32'(de), 0); end
                    3:   begin chk("lit_de3", 32'(de), 1);
                               chk("lit_rgb3", 32'(rgb), 32'h5A5); end
                    38:  chk("lit_hs_pre", 32'(hsync), 1);
                    39:  chk("lit_hs_on", 32'(hsync), 0);
                    44:  chk("lit_hs_last", 32'(hsync), 0);
                    45:  chk("lit_hs_off", 32'(hsync), 1);
                    445: chk("lit_rgb_5_9", 32'(rgb), 32'h5AC);
                    626: chk("lit_vs_pre", 32'(vsync), 1);
                    627: chk("lit_vs_on", 32'(vsync), 0);
                    815: chk("lit_fstart_815", 32'(frame_start), 0);
                    816: chk("lit_fstart_816", 32'(frame_start), 1);
                    default: ;
                endcase
            end else if (seg == 2) begin
                case (n_m)
                    813:  chk("lit_side_hold", 32'(fetch_side), 0);
                    815:  chk("lit_side_new", 32'(fetch_side), 1);
                    817:  begin chk("lit_first_addr", 32'(mif.rd_addr), 12);
                                chk("lit_first_rden", 32'(mif.rd_en), 1); end
                    1375: begin chk("lit_last_addr", 32'(mif.rd_addr), 23);
                                chk("lit_last_rden", 32'(mif.rd_en), 1); end
                    default: ;
                endcase
            end

            // The DUT samples side at the end of the last tick of each frame.
            if ((n_m % P == 0) && (t % F == F - 1)) fs_map[t / F + 1] = side;
            n_m++;
        end
    end

    // ---------------- stimulus ----------------
    bit side_rand = 1'b1;
    bit side_hold = 1'b0;

    initial forever begin
        @(posedge CLK);
        #1 side = side_rand ? 1'($urandom_range(0, 1)) : side_hold;
    end

    initial begin
        repeat (4) @(posedge CLK);
        #1 rst = 1'b0;
        // Two full frames plus part of a third with random side, then a
        // reset in mid-frame while the counters sit at h=9, v=5.
        repeat (2 * F * P + (5 * HT + 9) * P + 1) @(negedge CLK);
        @(posedge CLK);
        #1 rst = 1'b1;
        side_rand = 1'b0;
        side_hold = 1'b0;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        // Flip side mid-frame (line 5); it must only apply to the next frame.
        repeat (5 * HT * P + 1) @(negedge CLK);
        side_hold = 1'b1;
        repeat (1400) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
